// File: rtl/multi_quad_pwm.sv
// N-channel quadrature decoder and edge-aligned PWM engine with a Wishbone classic
// register slave (per channel: POSITION, DUTY, PERIOD, STATUS at adr[7:4]/[3:2]).
module multi_quad_pwm #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int PWM_WIDTH  = 12,
  parameter int RST_PERIOD = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_CH-1:0] enc_a,
  input  logic [NUM_CH-1:0] enc_b,
  output logic [NUM_CH-1:0] pwm_out
);

  logic [NUM_CH-1:0]    syncA1_q, syncA2_q, syncB1_q, syncB2_q;
  logic [NUM_CH-1:0]    curA_q, curB_q, prevA_q, prevB_q;
  logic [NUM_CH-1:0]    err_q, err_d, pwm_q, pwm_d;
  logic [CNT_WIDTH-1:0] pos_q [NUM_CH];
  logic [CNT_WIDTH-1:0] pos_d [NUM_CH];
  logic [PWM_WIDTH-1:0] dutySh_q [NUM_CH];
  logic [PWM_WIDTH-1:0] dutySh_d [NUM_CH];
  logic [PWM_WIDTH-1:0] periodSh_q [NUM_CH];
  logic [PWM_WIDTH-1:0] periodSh_d [NUM_CH];
  logic [PWM_WIDTH-1:0] dutyAct_q [NUM_CH];
  logic [PWM_WIDTH-1:0] dutyAct_d [NUM_CH];
  logic [PWM_WIDTH-1:0] periodAct_q [NUM_CH];
  logic [PWM_WIDTH-1:0] periodAct_d [NUM_CH];
  logic [PWM_WIDTH-1:0] pwmCnt_q [NUM_CH];
  logic [PWM_WIDTH-1:0] pwmCnt_d [NUM_CH];
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;

  logic        req, hit, wrEn;
  logic [3:0]  chSel;
  logic [1:0]  regSel;
  logic [31:0] rdata, merged;
  logic [3:0]  trans;
  logic        stepUp, stepDn, illegal, wrap;
  logic        unusedAdrBits;

  assign unusedAdrBits = ^wbs_adr_i[1:0];

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldV, input logic [31:0] newV,
                                             input logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? newV[8*b +: 8] : oldV[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
    chSel  = wbs_adr_i[7:4];
    regSel = wbs_adr_i[3:2];
    hit    = (wbs_adr_i[31:8] == 24'd0) && ({1'b0, chSel} < 5'(NUM_CH));
    wrEn   = req & wbs_we_i & hit;
    rdata  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit && chSel == 4'(i)) begin
        case (regSel)
          2'd0:    rdata = 32'(signed'(pos_q[i]));
          2'd1:    rdata = 32'(dutySh_q[i]);
          2'd2:    rdata = 32'(periodSh_q[i]);
          default: rdata = {31'd0, err_q[i]};
        endcase
      end
    end
    ack_d = req;
    dat_d = (req && !wbs_we_i) ? rdata : '0;
  end

  // Register writes are ordered after the encoder step so a bus write wins, while an
  // illegal transition is applied after the W1C clear so the error flag survives.
  always_comb begin
    pos_d       = pos_q;
    dutySh_d    = dutySh_q;
    periodSh_d  = periodSh_q;
    dutyAct_d   = dutyAct_q;
    periodAct_d = periodAct_q;
    pwmCnt_d    = pwmCnt_q;
    err_d       = err_q;
    pwm_d       = pwm_q;
    trans       = '0;
    stepUp      = 1'b0;
    stepDn      = 1'b0;
    illegal     = 1'b0;
    wrap        = 1'b0;
    merged      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      trans   = {prevA_q[i], prevB_q[i], curA_q[i], curB_q[i]};
      stepUp  = (trans == 4'b0010) || (trans == 4'b1011) || (trans == 4'b1101) || (trans == 4'b0100);
      stepDn  = (trans == 4'b1000) || (trans == 4'b1110) || (trans == 4'b0111) || (trans == 4'b0001);
      illegal = (prevA_q[i] != curA_q[i]) && (prevB_q[i] != curB_q[i]);
      if (stepUp)      pos_d[i] = pos_q[i] + CNT_WIDTH'(1);
      else if (stepDn) pos_d[i] = pos_q[i] - CNT_WIDTH'(1);

      if (wrEn && chSel == 4'(i)) begin
        case (regSel)
          2'd0: begin
            merged   = mergeBytes(32'(pos_q[i]), wbs_dat_i, wbs_sel_i);
            pos_d[i] = merged[CNT_WIDTH-1:0];
          end
          2'd1: begin
            merged      = mergeBytes(32'(dutySh_q[i]), wbs_dat_i, wbs_sel_i);
            dutySh_d[i] = merged[PWM_WIDTH-1:0];
          end
          2'd2: begin
            merged        = mergeBytes(32'(periodSh_q[i]), wbs_dat_i, wbs_sel_i);
            periodSh_d[i] = merged[PWM_WIDTH-1:0];
          end
          default: if (wbs_sel_i[0] && wbs_dat_i[0]) err_d[i] = 1'b0;
        endcase
      end
      if (illegal) err_d[i] = 1'b1;

      // Shadow values only reach the comparator at the wrap, so a period never gets cut short.
      wrap = (pwmCnt_q[i] >= periodAct_q[i]);
      if (wrap) begin
        pwmCnt_d[i]    = '0;
        dutyAct_d[i]   = dutySh_q[i];
        periodAct_d[i] = periodSh_q[i];
      end else begin
        pwmCnt_d[i] = pwmCnt_q[i] + PWM_WIDTH'(1);
      end
      pwm_d[i] = (pwmCnt_q[i] < dutyAct_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      syncA1_q <= '0;
      syncA2_q <= '0;
      syncB1_q <= '0;
      syncB2_q <= '0;
      curA_q   <= '0;
      curB_q   <= '0;
      prevA_q  <= '0;
      prevB_q  <= '0;
      err_q    <= '0;
      pwm_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pos_q[i]       <= '0;
        dutySh_q[i]    <= '0;
        periodSh_q[i]  <= PWM_WIDTH'(RST_PERIOD);
        dutyAct_q[i]   <= '0;
        periodAct_q[i] <= PWM_WIDTH'(RST_PERIOD);
        pwmCnt_q[i]    <= '0;
      end
    end else begin
      syncA1_q <= enc_a;
      syncA2_q <= syncA1_q;
      syncB1_q <= enc_b;
      syncB2_q <= syncB1_q;
      curA_q   <= syncA2_q;
      curB_q   <= syncB2_q;
      prevA_q  <= curA_q;
      prevB_q  <= curB_q;
      err_q    <= err_d;
      pwm_q    <= pwm_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      for (int i = 0; i < NUM_CH; i++) begin
        pos_q[i]       <= pos_d[i];
        dutySh_q[i]    <= dutySh_d[i];
        periodSh_q[i]  <= periodSh_d[i];
        dutyAct_q[i]   <= dutyAct_d[i];
        periodAct_q[i] <= periodAct_d[i];
        pwmCnt_q[i]    <= pwmCnt_d[i];
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_multi_quad_pwm.sv
// Bench for multi_quad_pwm: Wishbone reads are scored against a queue of expected
// values built from a small encoder/PWM model kept here.
module tb_multi_quad_pwm;

  localparam int NUM_CH     = 4;
  localparam int CNT_WIDTH  = 16;
  localparam int PWM_WIDTH  = 12;
  localparam int RST_PERIOD = 4095;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]        sel = 4'h0;
  logic [31:0]       adr = '0, datI = '0;
  logic              ack;
  logic [31:0]       datO;
  logic [NUM_CH-1:0] encA = '0, encB = '0;
  logic [NUM_CH-1:0] pwmOut;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expQ[$];
  logic [31:0] rd, expV;
  logic [1:0]  quadSeq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          encState [NUM_CH] = '{default: 0};

  always #5 clk = ~clk;

  multi_quad_pwm #(
    .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH), .PWM_WIDTH(PWM_WIDTH), .RST_PERIOD(RST_PERIOD)
  ) dut (
    .clk(clk), .reset(reset),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(datI), .wbs_ack_o(ack), .wbs_dat_o(datO),
    .enc_a(encA), .enc_b(encB), .pwm_out(pwmOut)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] regAdr(input int ch, input int r);
    return 32'((ch << 4) | (r << 2));
  endfunction

  // Returns X data if no ack arrives within the bound, so the caller's compare fails.
  task automatic wbXfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r);
    bit got;
    got = 1'b0;
    r = 'x;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; datI = d; sel = s;
    for (int n = 0; n < 8 && !got; n++) begin
      tick();
      if (ack === 1'b1) begin
        r = datO;
        got = 1'b1;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wbRead(input logic [31:0] a, output logic [31:0] r);
    wbXfer(1'b0, a, 32'd0, 4'hF, r);
  endtask

  task automatic wbWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    wbXfer(1'b1, a, d, s, dummy);
  endtask

  task automatic stepEnc(input int ch, input int dir);
    encState[ch] = (encState[ch] + dir + 4) % 4;
    encA[ch] = quadSeq[encState[ch]][1];
    encB[ch] = quadSeq[encState[ch]][0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++;
    if (pwmOut !== '0) begin errors++; $display("[TB] FAIL rst_pwm: got %b want 0", pwmOut); end
    checks++;
    if (ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack: got %b want 0", ack); end
    checks++;
    if (datO !== 32'd0) begin errors++; $display("[TB] FAIL rst_dat: got %h want 0", datO); end
    reset = 1'b0;
    tick();
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int r = 0; r < 4; r++) expQ.push_back((r == 2) ? 32'(RST_PERIOD) : 32'd0);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int r = 0; r < 4; r++) begin
        wbRead(regAdr(ch, r), rd);
        expV = expQ.pop_front();
        checks++;
        if (rd !== expV) begin
          errors++;
          $display("[TB] FAIL rst_reg ch%0d r%0d: got %h want %h", ch, r, rd, expV);
        end
      end
    end
  endtask

  task automatic test_quad_count();
    int expPos;
    expPos = 0;
    for (int k = 0; k < 8; k++) begin stepEnc(1, 1); expPos++; tick(5); end
    expQ.push_back(32'(expPos));
    wbRead(regAdr(1, 0), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL ch1_fwd8: got %h want %h", rd, expV); end
    for (int k = 0; k < 10; k++) begin stepEnc(1, -1); expPos--; tick(5); end
    expQ.push_back(32'(expPos));
    wbRead(regAdr(1, 0), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL ch1_rev10: got %h want %h", rd, expV); end
    // Read acked on edge k+3 still sees the old count; one acked on edge k+4 sees the new.
    expQ.push_back(32'(expPos));
    stepEnc(1, 1); expPos++;
    tick(3);
    wbRead(regAdr(1, 0), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL ch1_lat_early: got %h want %h", rd, expV); end
    stepEnc(1, 1); expPos++;
    expQ.push_back(32'(expPos));
    tick(4);
    wbRead(regAdr(1, 0), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL ch1_lat_land: got %h want %h", rd, expV); end
  endtask

  task automatic test_illegal_wrap();
    encA[0] = 1'b1; encB[0] = 1'b1; encState[0] = 2;
    tick(5);
    expQ.push_back(32'd0);
    expQ.push_back(32'd1);
    wbRead(regAdr(0, 0), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL ch0_illegal_pos: got %h want %h", rd, expV); end
    wbRead(regAdr(0, 3), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL ch0_err_set: got %h want %h", rd, expV); end
    wbWrite(regAdr(0, 3), 32'd1, 4'hF);
    expQ.push_back(32'd0);
    wbRead(regAdr(0, 3), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL ch0_err_clr: got %h want %h", rd, expV); end
    wbWrite(regAdr(0, 0), 32'h0000_7FFF, 4'hF);
    stepEnc(0, 1);
    tick(5);
    expQ.push_back(32'hFFFF_8000);
    expQ.push_back(32'd0);
    wbRead(regAdr(0, 0), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL ch0_wrap: got %h want %h", rd, expV); end
    wbRead(regAdr(0, 3), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL ch0_err_legal: got %h want %h", rd, expV); end
  endtask

  task automatic test_pwm();
    logic prev, found, e;
    wbWrite(regAdr(2, 2), 32'd9, 4'hF);
    wbWrite(regAdr(2, 1), 32'd3, 4'hF);
    tick(4200);
    prev = pwmOut[2];
    found = 1'b0;
    for (int n = 0; n < 25 && !found; n++) begin
      tick();
      if (!prev && pwmOut[2]) found = 1'b1;
      prev = pwmOut[2];
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL pwm_sync: got no rising edge want one within 25 clks"); end
    for (int i = 1; i < 30; i++) begin
      expQ.push_back(32'((i % 10) < 3));
      tick();
      expV = expQ.pop_front();
      checks++;
      if (32'(pwmOut[2]) !== expV) begin
        errors++;
        $display("[TB] FAIL pwm_3of10 idx%0d: got %b want %0d", i, pwmOut[2], expV);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      e = (pass == 1);
      wbWrite(regAdr(2, 1), (pass == 0) ? 32'd0 : 32'd20, 4'hF);
      tick(13);
      for (int i = 0; i < 12; i++) begin
        expQ.push_back(32'(e));
        tick();
        expV = expQ.pop_front();
        checks++;
        if (32'(pwmOut[2]) !== expV) begin
          errors++;
          $display("[TB] FAIL pwm_const pass%0d idx%0d: got %b want %0d", pass, i, pwmOut[2], expV);
        end
      end
    end
    wbWrite(regAdr(2, 1), 32'd3, 4'hF);
    tick(13);
    prev = pwmOut[2];
    found = 1'b0;
    for (int n = 0; n < 25 && !found; n++) begin
      tick();
      if (!prev && pwmOut[2]) found = 1'b1;
      prev = pwmOut[2];
    end
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL pwm_resync: got no rising edge want one within 25 clks"); end
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = regAdr(2, 1); datI = 32'd6; sel = 4'hF;
    for (int i = 1; i < 20; i++) begin
      expQ.push_back(32'((i < 10) ? (i < 3) : ((i - 10) < 6)));
      tick();
      if (i == 1) begin
        checks++;
        if (ack !== 1'b1) begin errors++; $display("[TB] FAIL pwm_mid_ack: got %b want 1", ack); end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
      end
      expV = expQ.pop_front();
      checks++;
      if (32'(pwmOut[2]) !== expV) begin
        errors++;
        $display("[TB] FAIL pwm_midchange idx%0d: got %b want %0d", i, pwmOut[2], expV);
      end
    end
    checks++;
    if (pwmOut[3] !== 1'b0 || pwmOut[1:0] !== 2'b00) begin
      errors++;
      $display("[TB] FAIL pwm_others: got %b want x0x00 pattern", pwmOut);
    end
  endtask

  task automatic test_wb_decode();
    wbWrite(32'h0000_00F4, 32'h0000_0123, 4'hF);
    wbWrite(32'h0000_0104, 32'h0000_0077, 4'hF);
    expQ.push_back(32'd0);
    wbRead(32'h0000_00F4, rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL bad_ch_read: got %h want %h", rd, expV); end
    expQ.push_back(32'd0);
    wbRead(32'h0000_0104, rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL hi_adr_read: got %h want %h", rd, expV); end
    for (int ch = 0; ch < NUM_CH; ch++) expQ.push_back((ch == 2) ? 32'd6 : 32'd0);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      wbRead(regAdr(ch, 1), rd);
      expV = expQ.pop_front();
      checks++;
      if (rd !== expV) begin errors++; $display("[TB] FAIL duty_untouched ch%0d: got %h want %h", ch, rd, expV); end
    end
    wbWrite(regAdr(3, 1), 32'h0000_ABCD, 4'b0001);
    expQ.push_back(32'h0000_00CD);
    wbRead(regAdr(3, 1), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL sel_lane0: got %h want %h", rd, expV); end
    wbWrite(regAdr(3, 1), 32'h0000_1234, 4'b0010);
    expQ.push_back(32'h0000_02CD);
    wbRead(regAdr(3, 1), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL sel_lane1: got %h want %h", rd, expV); end
    wbWrite(regAdr(3, 2), 32'h00FF_0000, 4'b1100);
    expQ.push_back(32'(RST_PERIOD));
    wbRead(regAdr(3, 2), rd);
    expV = expQ.pop_front();
    checks++;
    if (rd !== expV) begin errors++; $display("[TB] FAIL sel_upper_ignored: got %h want %h", rd, expV); end
  endtask

  task automatic test_back_to_back();
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = regAdr(3, 1); sel = 4'hF;
    tick();
    checks++;
    if (ack !== 1'b1 || datO !== 32'h0000_02CD) begin
      errors++; $display("[TB] FAIL b2b_first: got ack=%b dat=%h want ack=1 dat=000002cd", ack, datO);
    end
    tick();
    checks++;
    if (ack !== 1'b0 || datO !== 32'd0) begin
      errors++; $display("[TB] FAIL b2b_gap: got ack=%b dat=%h want ack=0 dat=0", ack, datO);
    end
    tick();
    checks++;
    if (ack !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: got ack=%b want 1", ack); end
    stb = 1'b0; cyc = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got ack=%b want 0", ack); end
  endtask

  task automatic test_reset_mid();
    encA = '0; encB = '0;
    for (int ch = 0; ch < NUM_CH; ch++) encState[ch] = 0;
    wbWrite(regAdr(2, 1), 32'd6, 4'hF);
    tick(20);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = regAdr(0, 1); datI = 32'h55; sel = 4'hF;
    reset = 1'b1;
    tick();
    checks++;
    if (ack !== 1'b0 || datO !== 32'd0 || pwmOut !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outs: got ack=%b dat=%h pwm=%b want 0/0/0", ack, datO, pwmOut);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'(RST_PERIOD));
    expQ.push_back(32'd0);
    for (int k = 0; k < 4; k++) begin
      wbRead((k == 0) ? regAdr(0, 1) : (k == 1) ? regAdr(2, 1) : (k == 2) ? regAdr(2, 2) : regAdr(1, 0), rd);
      expV = expQ.pop_front();
      checks++;
      if (rd !== expV) begin errors++; $display("[TB] FAIL mid_reset_reg%0d: got %h want %h", k, rd, expV); end
    end
    tick(12);
    checks++;
    if (pwmOut !== '0) begin errors++; $display("[TB] FAIL mid_reset_pwm: got %b want 0", pwmOut); end
  endtask

  initial begin
    test_reset();
    test_quad_count();
    test_illegal_wrap();
    test_pwm();
    test_wb_decode();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion want completion by 500us");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
